pll_reset_sequencer: RTL and testbench

Sequences bring-up of the SB_PLL40_CORE clock subsystem from the free-running 16MHz reference clock.
- Holds the PLL in reset for a fixed time, then waits for LOCK with a timeout.
- Retries a bounded number of times, then releases downstream reset domains one stage at a time.
- Monitors LOCK afterwards: lock loss re-asserts all resets and restarts the sequence.
- Sits between the board RESETB pin and the PLL/reset-synchroniser logic; every output is in the clk_in domain.

---
 rtl/pll_reset_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staged reset release sequencer, clocked by the 16MHz reference.
// Optional macro LOCK_DEBOUNCE_EN: require LOCK_STABLE consecutive lock cycles before release.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_DELAY    = 8,
    parameter int LOCK_STABLE    = 64
) (
    input  logic                  clk_in,
    input  logic                  resetb_in,
    input  logic                  pll_lock_in,
    input  logic                  restart_req,
    output logic                  pll_resetb_out,
    output logic [NUM_STAGES-1:0] resetb_out,
    output logic                  running,
    output logic                  fault,
    output logic [3:0]            retry_count
);

    // state     | meaning
    // RESET_PLL | PLL held in reset for PLL_RST_CYCLES
    // WAIT_LOCK | PLL released, waiting for (qualified) lock or timeout
    // RELEASE   | stage resets released one per STAGE_DELAY, bit 0 first
    // RUN       | all stages released, watching for lock loss
    // FAULT     | retries exhausted, everything held in reset

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (STAGE_DELAY > LOCK_STABLE) ? STAGE_DELAY : LOCK_STABLE;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STG_LAST  = CW'(STAGE_DELAY - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            sync_q;
    logic                  lock_s;
    logic                  lock_ok;
    logic                  pll_d;
    logic [NUM_STAGES-1:0] rb_d;
    logic [NUM_STAGES-1:0] rel_mask;
    logic                  run_d;
    logic                  fault_d;
    logic [3:0]            retry_d;

    assign lock_s = sync_q[1];

    // Current mask with one more stage released; covers the WAIT_LOCK exit too.
    assign rel_mask = NUM_STAGES'({resetb_out, 1'b1});

    always_ff @(posedge clk_in or negedge resetb_in) begin
        if (!resetb_in) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock_in};
        end
    end

`ifdef LOCK_DEBOUNCE_EN
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
    logic [CW-1:0] stab_q;

    always_ff @(posedge clk_in or negedge resetb_in) begin
        if (!resetb_in) begin
            stab_q <= '0;
        end else if (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK && lock_s) begin
            stab_q <= stab_q + CW'(1);
        end else begin
            stab_q <= '0;
        end
    end

    assign lock_ok = lock_s && (stab_q == STB_LAST);
`else
    assign lock_ok = lock_s;
`endif

    always_ff @(posedge clk_in or negedge resetb_in) begin
        if (!resetb_in) begin
            state_q        <= S_RESET_PLL;
            cnt_q          <= '0;
            pll_resetb_out <= 1'b0;
            resetb_out     <= '0;
            running        <= 1'b0;
            fault          <= 1'b0;
            retry_count    <= 4'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pll_resetb_out <= pll_d;
            resetb_out     <= rb_d;
            running        <= run_d;
            fault          <= fault_d;
            retry_count    <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        pll_d   = pll_resetb_out;
        rb_d    = resetb_out;
        run_d   = running;
        fault_d = fault;
        retry_d = retry_count;

        if (restart_req) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            pll_d   = 1'b0;
            rb_d    = '0;
            run_d   = 1'b0;
            fault_d = 1'b0;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    pll_d = 1'b0;
                    rb_d  = '0;
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                        pll_d   = 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_ok) begin
                        cnt_d   = '0;
                        rb_d    = rel_mask;
                        state_d = S_RELEASE;
                        if (rel_mask[NUM_STAGES-1]) begin
                            state_d = S_RUN;
                            run_d   = 1'b1;
                            retry_d = 4'd0;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d = '0;
                        pll_d = 1'b0;
                        if (retry_count == RETRY_MAX) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = S_RESET_PLL;
                            retry_d = retry_count + 4'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) begin
                        state_d = S_RESET_PLL;
                        cnt_d   = '0;
                        pll_d   = 1'b0;
                        rb_d    = '0;
                        run_d   = 1'b0;
                    end else if (cnt_q == STG_LAST) begin
                        cnt_d = '0;
                        rb_d  = rel_mask;
                        if (rel_mask[NUM_STAGES-1]) begin
                            state_d = S_RUN;
                            run_d   = 1'b1;
                            retry_d = 4'd0;
                        end
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d = S_RESET_PLL;
                        pll_d   = 1'b0;
                        rb_d    = '0;
                        run_d   = 1'b0;
                    end
                end
                S_FAULT: begin
                    cnt_d   = '0;
                    pll_d   = 1'b0;
                    rb_d    = '0;
                    fault_d = 1'b1;
                end
                default: begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: hand-derived vector table, corner sequences and a
// randomized run checked every cycle against a time-based reference model.
module tb_pll_reset_sequencer;

    localparam int PLL_RST_CYCLES = 16;
    localparam int LOCK_TIMEOUT   = 1024;
    localparam int MAX_RETRIES    = 3;
    localparam int NUM_STAGES     = 3;
    localparam int STAGE_DELAY    = 8;
    localparam int LOCK_STABLE    = 64;
    localparam int OW             = NUM_STAGES + 7;
`ifdef LOCK_DEBOUNCE_EN
    localparam int NEED_STABLE = LOCK_STABLE;
`else
    localparam int NEED_STABLE = 1;
`endif

    logic                  clk_in = 1'b0;
    logic                  resetb_in;
    logic                  pll_lock_in;
    logic                  restart_req;
    logic                  pll_resetb_out;
    logic [NUM_STAGES-1:0] resetb_out;
    logic                  running;
    logic                  fault;
    logic [3:0]            retry_count;
    logic [OW-1:0]         dut_vec;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .MAX_RETRIES   (MAX_RETRIES),
        .NUM_STAGES    (NUM_STAGES),
        .STAGE_DELAY   (STAGE_DELAY),
        .LOCK_STABLE   (LOCK_STABLE)
    ) dut (
        .clk_in        (clk_in),
        .resetb_in     (resetb_in),
        .pll_lock_in   (pll_lock_in),
        .restart_req   (restart_req),
        .pll_resetb_out(pll_resetb_out),
        .resetb_out    (resetb_out),
        .running       (running),
        .fault         (fault),
        .retry_count   (retry_count)
    );

    initial forever #5 clk_in = ~clk_in;

    assign dut_vec = {pll_resetb_out, resetb_out, running, fault, retry_count};

    // Reference model: phase + time spent in phase; lock pin seen two edges late.
    localparam int PH_HOLD  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_REL   = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    int phase, t_in_phase, released, stable, retries;
    bit lock_pipe[$];

    task automatic m_enter(input int ph);
        phase      = ph;
        t_in_phase = 0;
        stable     = 0;
        released   = 0;
    endtask

    task automatic m_reset();
        m_enter(PH_HOLD);
        retries = 0;
        lock_pipe.delete();
        lock_pipe.push_back(1'b0);
        lock_pipe.push_back(1'b0);
    endtask

    task automatic m_step(input bit pin, input bit rst_req);
        bit seen;
        seen = lock_pipe.pop_front();
        lock_pipe.push_back(pin);
        t_in_phase++;
        if (rst_req) begin
            retries = 0;
            m_enter(PH_HOLD);
        end else begin
            case (phase)
                PH_HOLD: if (t_in_phase == PLL_RST_CYCLES) m_enter(PH_WAIT);
                PH_WAIT: begin
                    stable = seen ? stable + 1 : 0;
                    if (stable >= NEED_STABLE) begin
                        m_enter(PH_REL);
                        released = 1;
                        if (released >= NUM_STAGES) begin
                            m_enter(PH_RUN);
                            retries = 0;
                        end
                    end else if (t_in_phase == LOCK_TIMEOUT) begin
                        if (retries == MAX_RETRIES) m_enter(PH_FAULT);
                        else begin
                            retries++;
                            m_enter(PH_HOLD);
                        end
                    end
                end
                PH_REL: begin
                    if (!seen) m_enter(PH_HOLD);
                    else begin
                        released = 1 + t_in_phase / STAGE_DELAY;
                        if (released >= NUM_STAGES) begin
                            m_enter(PH_RUN);
                            retries = 0;
                        end
                    end
                end
                PH_RUN: if (!seen) m_enter(PH_HOLD);
                default: ;
            endcase
        end
    endtask

    function automatic logic [OW-1:0] m_outputs();
        logic [NUM_STAGES-1:0] rb;
        logic                  pll;
        rb  = '0;
        pll = (phase == PH_WAIT) || (phase == PH_REL) || (phase == PH_RUN);
        for (int i = 0; i < NUM_STAGES; i++)
            rb[i] = (phase == PH_RUN) || (phase == PH_REL && i < released);
        return {pll, rb, phase == PH_RUN, phase == PH_FAULT, 4'(retries)};
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk_in or negedge resetb_in);
            if (!resetb_in) m_reset();
            else m_step(pll_lock_in, restart_req);
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (chk_en) begin
            n_tests++;
            if (dut_vec !== m_outputs()) begin
                n_fail++;
                $display("FAIL model_cmp at %0t: got %b required %b", $time, dut_vec, m_outputs());
            end
        end
    end

    task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    typedef struct {
        int            cycles;
        bit            pin;
        bit            restart;
        logic [OW-1:0] exp;
    } vec_t;

    function automatic vec_t mk(input int c, input bit pin, input bit rs, input bit p,
                                input logic [NUM_STAGES-1:0] rb, input bit run,
                                input bit f, input int r);
        vec_t v;
        v.cycles  = c;
        v.pin     = pin;
        v.restart = rs;
        v.exp     = {p, rb, run, f, 4'(r)};
        return v;
    endfunction

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            restart_req = 1'b0;
        end
    endtask

    vec_t vecs[$];
    int   seg_len;
    bit   reached;

    initial begin
        resetb_in   = 1'b0;
        pll_lock_in = 1'b0;
        restart_req = 1'b0;
        @(posedge clk_in);
        chk_en = 1'b1;
        @(negedge clk_in);
        check("reset_values", dut_vec, '0);
        @(negedge clk_in);
        resetb_in = 1'b1;

`ifndef LOCK_DEBOUNCE_EN
        vecs.push_back(mk(15,   0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(84,   0, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(2,    1, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 1, 3'b001, 0, 0, 0));
        vecs.push_back(mk(7,    1, 0, 1, 3'b001, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(7,    1, 0, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 1, 3'b111, 1, 0, 0));
        vecs.push_back(mk(20,   1, 0, 1, 3'b111, 1, 0, 0));
        vecs.push_back(mk(1,    0, 0, 1, 3'b111, 1, 0, 0));
        vecs.push_back(mk(1,    1, 0, 1, 3'b111, 1, 0, 0));
        vecs.push_back(mk(1,    1, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(15,   1, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 1, 3'b001, 0, 0, 0));
        vecs.push_back(mk(8,    1, 0, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(16,   1, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1,    1, 0, 1, 3'b001, 0, 0, 0));
        vecs.push_back(mk(8,    1, 0, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(8,    1, 0, 1, 3'b111, 1, 0, 0));
        vecs.push_back(mk(3,    0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(16,   0, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1023, 0, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 0, 3'b000, 0, 0, 1));
        vecs.push_back(mk(16,   0, 0, 1, 3'b000, 0, 0, 1));
        vecs.push_back(mk(1024, 0, 0, 0, 3'b000, 0, 0, 2));
        vecs.push_back(mk(1040, 0, 0, 0, 3'b000, 0, 0, 3));
        vecs.push_back(mk(16,   0, 0, 1, 3'b000, 0, 0, 3));
        vecs.push_back(mk(1023, 0, 0, 1, 3'b000, 0, 0, 3));
        vecs.push_back(mk(1,    0, 0, 0, 3'b000, 0, 1, 3));
        vecs.push_back(mk(50,   0, 0, 0, 3'b000, 0, 1, 3));
        vecs.push_back(mk(1,    0, 1, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(15,   0, 0, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1,    0, 0, 1, 3'b000, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            pll_lock_in = vecs[i].pin;
            restart_req = vecs[i].restart;
            cycles(vecs[i].cycles);
            check($sformatf("vec%0d", i), dut_vec, vecs[i].exp);
        end
`else
        cycles(PLL_RST_CYCLES);
        pll_lock_in = 1'b1;
        cycles(40);
        pll_lock_in = 1'b0;
        cycles(1);
        pll_lock_in = 1'b1;
        cycles(65);
        check("deb_not_yet", {pll_resetb_out, resetb_out}, {1'b1, 3'b000});
        cycles(1);
        check("deb_release", {pll_resetb_out, resetb_out}, {1'b1, 3'b001});
        pll_lock_in = 1'b0;
        restart_req = 1'b1;
        cycles(1);
        for (int i = 0; i < 1039; i++) begin
            pll_lock_in = ((i / 30) % 2) == 1;
            cycles(1);
        end
        check("deb_to_before", {pll_resetb_out, retry_count}, {1'b1, 4'd0});
        cycles(1);
        check("deb_timeout", {pll_resetb_out, retry_count}, {1'b0, 4'd1});
`endif

        // Restart coinciding with lock loss in RUN.
        pll_lock_in = 1'b1;
        restart_req = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            cycles(1);
            reached = running;
        end
        check("reach_run", {7'd0, reached}, 8'd1);
        pll_lock_in = 1'b0;
        cycles(2);
        restart_req = 1'b1;
        @(negedge clk_in);
        restart_req = 1'b0;
        check("restart_and_loss", dut_vec, '0);
        cycles(16);
        check("restart_hold16", dut_vec, {1'b1, 3'b000, 1'b0, 1'b0, 4'd0});

        // Asynchronous reset in the middle of RELEASE.
        pll_lock_in = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            cycles(1);
            reached = (resetb_out == 3'b001);
        end
        check("reach_release", {7'd0, reached}, 8'd1);
        @(posedge clk_in);
        #2;
        resetb_in = 1'b0;
        #1;
        check("async_reset", dut_vec, '0);
        cycles(3);
        resetb_in = 1'b1;

        // Randomized traffic against the model.
        for (int seg = 0; seg < 120; seg++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                pll_lock_in = 1'b1;
                seg_len = int'($urandom_range(10, 400));
            end else if (r < 85) begin
                pll_lock_in = 1'b0;
                seg_len = int'($urandom_range(1, 4));
            end else if (r < 93) begin
                pll_lock_in = 1'b0;
                seg_len = int'($urandom_range(1100, 1300));
            end else if (r < 97) begin
                restart_req = 1'b1;
                pll_lock_in = $urandom_range(0, 1) == 1;
                seg_len = int'($urandom_range(1, 50));
            end else begin
                @(posedge clk_in);
                #3;
                resetb_in = 1'b0;
                cycles(2);
                resetb_in = 1'b1;
                seg_len = int'($urandom_range(1, 20));
            end
            cycles(seg_len);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
